// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-based arbiter sharing one FIFO write port among REQS requesters.
// Grant state is registered; accept/write path is combinational so a full FIFO is never written.
module fifo_wr_arbiter #(
  parameter int unsigned N         = 8,
  parameter int unsigned REQS      = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REQS-1:0]      req,
  input  logic [REQS*N-1:0]    data_in,
  output logic [REQS-1:0]      ack,
  output logic [REQS-1:0]      gnt,
  output logic                 wr_en,
  output logic [N-1:0]         wr_data,
  input  logic                 fifo_Full,
  output logic                 busy
);

  localparam int unsigned PW = (REQS > 1) ? $clog2(REQS) : 1;
  localparam int unsigned CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t          r_state;
  logic [REQS-1:0] r_gnt;
  logic [PW-1:0]   r_gidx;
  logic [PW-1:0]   r_rr_ptr;
  logic [CW-1:0]   r_burst_cnt;
  logic            r_busy;

  logic [PW-1:0]   w_start;
  logic [PW-1:0]   w_scan;
  logic [PW-1:0]   w_win_idx;
  logic            w_win_found;
  logic [REQS-1:0] w_win_onehot;
  logic            w_accept;
  logic            w_last;
  logic            w_release;

  // On release the scan starts just past the current owner, which is also the new rr_ptr
  always_comb begin
    w_start = r_rr_ptr;
    if (r_state == S_BURST) begin
      w_start = (r_gidx == PW'(REQS - 1)) ? '0 : r_gidx + PW'(1);
    end
  end

  // Descending scan so the requester closest to w_start is the last (winning) assignment
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_scan      = '0;
    for (int k = REQS - 1; k >= 0; k--) begin
      w_scan = PW'((int'(w_start) + k) % int'(REQS));
      if (req[w_scan]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_scan;
      end
    end
  end

  assign w_win_onehot = REQS'(1) << w_win_idx;

  assign ack      = r_gnt & req & {REQS{~fifo_Full}};
  assign wr_en    = |ack;
  assign w_accept = wr_en;
  assign w_last   = (r_burst_cnt == CW'(MAX_BURST - 1));
  assign w_release = (r_state == S_BURST) && ((w_accept && w_last) || !req[r_gidx]);

  always_comb begin
    wr_data = '0;
    for (int i = 0; i < REQS; i++) begin
      wr_data = wr_data | (data_in[i*N +: N] & {N{r_gnt[i]}});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_gidx      <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_win_found) begin
            r_gnt       <= w_win_onehot;
            r_gidx      <= w_win_idx;
            r_burst_cnt <= '0;
            r_state     <= S_BURST;
            r_busy      <= 1'b1;
          end else begin
            r_gnt <= '0;
          end
        end
        S_BURST: begin
          if (w_release) begin
            r_rr_ptr <= w_start;
            if (w_win_found) begin
              r_gnt       <= w_win_onehot;
              r_gidx      <= w_win_idx;
              r_burst_cnt <= '0;
            end else begin
              r_gnt   <= '0;
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else if (w_accept) begin
            r_burst_cnt <= r_burst_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt  = r_gnt;
  assign busy = r_busy;

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter placed in front of the `asy_fifo` write side, in the write clock domain. It shares the single FIFO write port (`wr_en`/`wr_data`) among `REQS` requesters. Grants are burst-based, up to `MAX_BURST` words per grant, and it applies FIFO backpressure via `fifo_Full`. Grant state is registered; the accept path is combinational so no word is ever issued into a full FIFO.

## Interface
- `N`, 8, data width; matches the FIFO `N`.
- `REQS`, 4, number of requesters, ≥2.
- `MAX_BURST`, 4, maximum words accepted per grant, ≥1.

- `clk`  in  1  write-domain clock; connects to the FIFO `wr_clk`.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  REQS  per-requester valid; `req[i]` high means `data_in` slice i holds a word.
- `data_in`  in  REQS*N  packed requester data; slice i is `[i*N +: N]`.
- `ack`  out  REQS  per-requester accept strobe; the word is consumed this cycle.
- `gnt`  out  REQS  registered one-hot grant (all-zero when idle).
- `wr_en`  out  1  FIFO write enable.
- `wr_data`  out  N  FIFO write data.
- `fifo_Full`  in  1  FIFO full flag (write domain).
- `busy`  out  1  high while state is BURST.

## Operation
- **State registers:**
  - `state` ∈ {IDLE, BURST}.
  - `gnt` (one-hot).
  - `rr_ptr` (clog2(REQS) bits): start index for the next arbitration.
  - `burst_cnt` (max(1, clog2(MAX_BURST)) bits).
- **Arbitration function:** the first i with `req[i]` high, scanning `rr_ptr`, `rr_ptr+1`, … mod REQS.
- **Accept (combinational):** `ack[i] = gnt[i] & req[i] & ~fifo_Full`.
  - `wr_en = |ack`.
  - `wr_data` = slice of the granted index; it equals 0 when `gnt` = 0.
- **IDLE:**
  - If `|req`: load `gnt` with the arbitration result, `burst_cnt` ← 0, go to BURST.
  - Otherwise stay in IDLE with `gnt` = 0.
- **BURST, granted index g:**
  - **Accept with `burst_cnt` < MAX_BURST-1:** `burst_cnt` increments.
  - **Release on last word:** accept with `burst_cnt` = MAX_BURST-1.
  - **Release on drop:** `req[g]` low.
  - **On release:**
    - `rr_ptr` ← (g+1) mod REQS.
    - Re-arbitrate in the same cycle using the new start index over the current `req`.
    - If a winner exists, load the new `gnt`, `burst_cnt` ← 0, stay in BURST. Back-to-back bursts have no bubble; the same requester may win again if it is the only one requesting.
    - Otherwise go to IDLE, `gnt` ← 0.
  - **`fifo_Full` high:** no accept, `burst_cnt` holds, grant is held indefinitely (no timeout). A `req[g]` drop while full still releases.
- A `req[i]` for a non-granted i is never acked. Requesters hold `req`/data stable until acked.
- `rr_ptr` changes only on release.

## Timing
- **Reset (async, immediate):** `state` = IDLE, `gnt` = 0, `rr_ptr` = 0, `burst_cnt` = 0. Consequently `ack` = 0, `wr_en` = 0, `wr_data` = 0, `busy` = 0.
- **Reset mid-burst:** the burst is abandoned. After `rst` falls, the first arbitration starts from index 0.
- **Grant latency:** `req` rising in IDLE at edge k gives `gnt` valid after edge k+1. The first `ack`/`wr_en` can occur in cycle k+1.
- **Throughput:** 1 word/cycle while not full, including across burst boundaries.
- **`fifo_Full`:** combinational to `wr_en`/`ack`, zero-cycle response.
- **Release on drop:** costs 0 bubbles if another requester is pending. The new grant is visible the cycle after the drop.

## Test plan
- **Reset mid-burst:** assert `rst` during a req1 burst → `gnt`, `ack`, `wr_en` drop to 0 without waiting for a clock edge. After release, with all `req` high, the first grant is `gnt` = 0001.
- **Single requester:** `req` = 0001 held, `fifo_Full` = 0, data increments 0x00.. → `gnt` = 0001 from cycle 1 onward. `wr_en` is continuously high and `wr_data` = 0x00,0x01,…. `burst_cnt` wraps every 4 words with no bubble.
- **Fairness:** `req` = 1111 held → grant order 0,1,2,3,0, 4 words each. 16 writes in cycles 1–16, with slice data 0x10/0x20/0x30/0x40 appearing in 4-word groups.
- **Backpressure:** during a req1 burst, `fifo_Full` is high for 3 cycles after word 2 → `wr_en`/`ack[1]` low for exactly those 3 cycles. `burst_cnt` holds at 2. The burst still delivers 4 words total and ends 3 cycles later.
- **Early drop:** `req` = 0110, req1 drops after 2 acks → next cycle `gnt` = 0100. `rr_ptr` = 2 after the release, and req2 gets a full 4-word burst.
- **Data mux:** `data_in` slices 0xA5, 0x5A, 0xC3, 0x3C with only `req[2]` high → `wr_data` = 0xC3 while `ack[2]` is high. `wr_data` = 0 while idle.
